ahb_lite_master: RTL and testbench

//  - AHB-Lite initiator: turns a simple valid/ready request port into single AHB transfers.
//  - Delivers a one-cycle response pulse per transfer.
//  - Sits between a core/DMA-style requester and the AHB fabric (e.g. the on-chip AHB RAM).
//  - Pipelined: the next address phase overlaps the current data phase.
//  - Max 1 address phase + 1 data phase in flight.

---
 rtl/ahb_lite_master.sv | 187 ++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator.
// Converts a valid/ready request port into pipelined AHB SINGLE transfers
// (one address phase overlapping one data phase) and returns one response
// pulse per transfer.
// Optional build macro: AHB_MST_ERR_CANCEL_EN -- when defined, an address
// phase pending during an ERROR response is dropped and answered with its own
// error response instead of being issued on the bus.
module ahb_lite_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        hclk,
    input  logic        hreset_n,
    // Request port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    // Response port
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    // AHB-Lite master interface
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] wdata_q, wdata_d;
    logic        dphase_q, dphase_d;
    logic        dwrite_q, dwrite_d;
    logic        err_hold_q, err_hold_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
`ifdef AHB_MST_ERR_CANCEL_EN
    logic        cancel_pend_q, cancel_pend_d;
`endif

    logic accept;
    logic aphase_done;
    logic dphase_done;
    logic err_first;

    // Request handshake and phase-completion qualifiers.
    always_comb begin
        req_ready   = ((htrans_q == HtransIdle) | hready) & ~err_hold_q;
        accept      = req_valid & req_ready;
        aphase_done = hready & (htrans_q == HtransNonseq);
        dphase_done = hready & dphase_q;
        // First cycle of the two-cycle ERROR response.
        err_first   = dphase_q & ~hready & hresp;
    end

    // Next-state for the address phase, data phase and response registers.
    always_comb begin
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        dphase_d    = dphase_q;
        dwrite_d    = dwrite_q;
        err_hold_d  = err_hold_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef AHB_MST_ERR_CANCEL_EN
        cancel_pend_d = cancel_pend_q;
`endif

        if (accept) begin
            htrans_d = HtransNonseq;
            haddr_d  = req_addr;
            hwrite_d = req_write;
            hsize_d  = req_size;
            wdata_d  = req_wdata;
        end else if (aphase_done) begin
            htrans_d = HtransIdle;
        end

        // Address phase moves into the data phase; a completing data phase
        // in the same cycle is simply replaced.
        if (aphase_done) begin
            dphase_d = 1'b1;
            dwrite_d = hwrite_q;
            hwdata_d = wdata_q;
        end else if (dphase_done) begin
            dphase_d = 1'b0;
        end

        if (dphase_done) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = hresp;
            if (!dwrite_q) begin
                rsp_rdata_d = hrdata;
            end
        end

        // Block new requests between the two ERROR cycles.
        if (err_first) begin
            err_hold_d = 1'b1;
        end else if (dphase_done) begin
            err_hold_d = 1'b0;
        end

`ifdef AHB_MST_ERR_CANCEL_EN
        // hready is low here, so no accept or phase completion can collide.
        if (err_first && (htrans_q == HtransNonseq)) begin
            htrans_d      = HtransIdle;
            cancel_pend_d = 1'b1;
        end
        // Dropped request answers one cycle after the errored response.
        if (cancel_pend_q && !dphase_q) begin
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            cancel_pend_d = 1'b0;
        end
`endif
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            htrans_q    <= HtransIdle;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            dphase_q    <= 1'b0;
            dwrite_q    <= 1'b0;
            err_hold_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef AHB_MST_ERR_CANCEL_EN
            cancel_pend_q <= 1'b0;
`endif
        end else begin
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            dphase_q    <= dphase_d;
            dwrite_q    <= dwrite_d;
            err_hold_q  <= err_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef AHB_MST_ERR_CANCEL_EN
            cancel_pend_q <= cancel_pend_d;
`endif
        end
    end

    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign hwdata    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master; the slave side is driven by hand.
// Honours AHB_MST_ERR_CANCEL_EN for the ERROR scenario.
module tb_ahb_lite_master;

    logic        hclk;
    logic        hreset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int n_vec  = 0;
    int n_fail = 0;

    ahb_lite_master dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hprot     (hprot),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then settle.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                             input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
    endtask

    initial begin
        hreset_n  = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 1'b0;

        #2;
        chk("rst_htrans", {30'd0, htrans}, 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("hburst", {29'd0, hburst}, 32'h0);
        chk("hprot", {28'd0, hprot}, 32'h3);
        @(posedge hclk);
        #3 hreset_n = 1'b1;

        // ---- 1: reset in the middle of a stall ----
        chk("t1_ready_idle", {31'd0, req_ready}, 32'h1);
        drive_req(1'b1, 3'd2, 32'h0000_0020, 32'hCAFE_F00D);
        tick();
        drive_req(1'b1, 3'd2, 32'h0000_0024, 32'h0000_0000);
        tick();
        req_valid = 1'b0;
        hready    = 1'b0;
        tick();
        chk("t1_stall_htrans", {30'd0, htrans}, 32'h2);
        chk("t1_stall_haddr", haddr, 32'h0000_0024);
        chk("t1_stall_hwdata", hwdata, 32'hCAFE_F00D);
        #2 hreset_n = 1'b0;
        #1;
        chk("t1_rst_htrans", {30'd0, htrans}, 32'h0);
        chk("t1_rst_haddr", haddr, 32'h0);
        chk("t1_rst_hwrite", {31'd0, hwrite}, 32'h0);
        chk("t1_rst_hsize", {29'd0, hsize}, 32'h0);
        chk("t1_rst_hwdata", hwdata, 32'h0);
        chk("t1_rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'h0);
        hready = 1'b1;
        @(negedge hclk);
        hreset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_post_rsp_valid", {31'd0, rsp_valid}, 32'h0);
            chk("t1_post_htrans", {30'd0, htrans}, 32'h0);
        end

        // ---- 2: zero-wait word read ----
        drive_req(1'b0, 3'd2, 32'h0000_0010, 32'h0);
        tick();
        chk("t2_htrans", {30'd0, htrans}, 32'h2);
        chk("t2_haddr", haddr, 32'h0000_0010);
        chk("t2_hctl", {27'd0, hwrite, 1'b0, hsize}, 32'h2);
        req_valid = 1'b0;
        tick();
        chk("t2_htrans_idle", {30'd0, htrans}, 32'h0);
        chk("t2_no_rsp_yet", {31'd0, rsp_valid}, 32'h0);
        hrdata = 32'hDEAD_BEEF;
        tick();
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'h1);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_rsp_err", {31'd0, rsp_err}, 32'h0);
        tick();
        chk("t2_rsp_pulse", {31'd0, rsp_valid}, 32'h0);

        // ---- 3: byte write ----
        hrdata = 32'h0;
        drive_req(1'b1, 3'd0, 32'h0000_0003, 32'hAB00_0000);
        tick();
        chk("t3_haddr", haddr, 32'h0000_0003);
        chk("t3_hctl", {27'd0, hwrite, 1'b0, hsize}, 32'h10);
        req_valid = 1'b0;
        tick();
        chk("t3_hwdata", hwdata, 32'hAB00_0000);
        tick();
        chk("t3_rsp", {30'd0, rsp_valid, rsp_err}, 32'h2);
        chk("t3_rdata_kept", rsp_rdata, 32'hDEAD_BEEF);

        // ---- 4: back-to-back writes ----
        drive_req(1'b1, 3'd2, 32'h0000_0000, 32'h1111_1111);
        tick();
        chk("t4_a0", {htrans, haddr[29:0]}, 32'h8000_0000);
        drive_req(1'b1, 3'd2, 32'h0000_0004, 32'h2222_2222);
        tick();
        chk("t4_a1", {htrans, haddr[29:0]}, 32'h8000_0004);
        chk("t4_d0", hwdata, 32'h1111_1111);
        drive_req(1'b1, 3'd2, 32'h0000_0008, 32'h3333_3333);
        tick();
        chk("t4_a2", {htrans, haddr[29:0]}, 32'h8000_0008);
        chk("t4_d1", hwdata, 32'h2222_2222);
        chk("t4_rsp0", {31'd0, rsp_valid}, 32'h1);
        req_valid = 1'b0;
        tick();
        chk("t4_idle", {30'd0, htrans}, 32'h0);
        chk("t4_d2", hwdata, 32'h3333_3333);
        chk("t4_rsp1", {31'd0, rsp_valid}, 32'h1);
        tick();
        chk("t4_rsp2", {31'd0, rsp_valid}, 32'h1);
        tick();
        chk("t4_rsp_end", {31'd0, rsp_valid}, 32'h0);

        // ---- 5: wait states with a next address pending ----
        drive_req(1'b0, 3'd2, 32'h0000_0040, 32'h5555_AAAA);
        tick();
        drive_req(1'b0, 3'd2, 32'h0000_0044, 32'h0000_0000);
        tick();
        req_valid = 1'b0;
        hready    = 1'b0;
        #1;
        chk("t5_ready_low", {31'd0, req_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_addr", {htrans, haddr[29:0]}, 32'h8000_0044);
            chk("t5_hold_wdata", hwdata, 32'h5555_AAAA);
            chk("t5_no_rsp", {31'd0, rsp_valid}, 32'h0);
        end
        hready = 1'b1;
        hrdata = 32'h0BAD_F00D;
        tick();
        chk("t5_rsp0", {30'd0, rsp_valid, rsp_err}, 32'h2);
        chk("t5_rdata0", rsp_rdata, 32'h0BAD_F00D);
        chk("t5_idle", {30'd0, htrans}, 32'h0);
        hrdata = 32'h1234_5678;
        tick();
        chk("t5_rsp1", {30'd0, rsp_valid, rsp_err}, 32'h2);
        chk("t5_rdata1", rsp_rdata, 32'h1234_5678);

        // ---- 6: ERROR with a read pending behind it ----
        drive_req(1'b0, 3'd2, 32'h0000_0004, 32'h0);
        tick();
        drive_req(1'b0, 3'd2, 32'h0000_0008, 32'h0);
        tick();
        req_valid = 1'b0;
        hready    = 1'b0;
        hresp     = 1'b1;
        hrdata    = 32'hEEEE_EEEE;
        tick();
        hready = 1'b1;
        #1;
        chk("t6_ready_held", {31'd0, req_ready}, 32'h0);
`ifdef AHB_MST_ERR_CANCEL_EN
        chk("t6_cancel_idle", {30'd0, htrans}, 32'h0);
`else
        chk("t6_pending_kept", {htrans, haddr[29:0]}, 32'h8000_0008);
`endif
        tick();
        chk("t6_err_rsp", {30'd0, rsp_valid, rsp_err}, 32'h3);
        chk("t6_ready_back", {31'd0, req_ready}, 32'h1);
        hresp  = 1'b0;
        hrdata = 32'h8888_8888;
`ifdef AHB_MST_ERR_CANCEL_EN
        chk("t6_no_issue", {30'd0, htrans}, 32'h0);
        tick();
        chk("t6_cancel_rsp", {30'd0, rsp_valid, rsp_err}, 32'h3);
        chk("t6_no_issue2", {30'd0, htrans}, 32'h0);
`else
        tick();
        chk("t6_second_rsp", {30'd0, rsp_valid, rsp_err}, 32'h2);
        chk("t6_second_rdata", rsp_rdata, 32'h8888_8888);
`endif
        tick();
        chk("t6_quiet", {31'd0, rsp_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
